fence_sequencer: RTL and testbench
==================================

# fence_sequencer

Multi-cycle sequencer for FENCE, FENCE.I and SFENCE.VMA. It sits beside the flush controller, between the commit stage and the caches/MMU. It latches a fence request, halts commit and drains the store buffer. It then runs the DCache flush handshake and, on completion, emits single-cycle pulses for the ICache flush, the TLB flush and the pipeline flush/PC redirect.

## Interface
Parameters:
- ACK_TIMEOUT, default 1024: max cycles in FLUSH waiting for `flush_dcache_ack_i`; 0 disables timeout.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- fence_i  in  1  FENCE committed (single-cycle pulse)
- fence_i_i  in  1  FENCE.I committed (pulse)
- sfence_vma_i  in  1  SFENCE.VMA committed (pulse)
- stores_empty_i  in  1  store buffer/committed stores fully drained
- flush_dcache_o  out  1  DCache flush request, level, held until ack
- flush_dcache_ack_i  in  1  DCache flush complete (pulse)
- flush_icache_o  out  1  ICache flush pulse
- flush_tlb_o  out  1  TLB flush pulse
- flush_pipeline_o  out  1  flush IF/ID/EX/unissued pulse
- set_pc_commit_o  out  1  redirect PC to commit PC + 4, pulse
- halt_o  out  1  stall commit while sequence active
- busy_o  out  1  sequencer not IDLE
- timeout_o  out  1  sticky: last flush ended by timeout; cleared on next accepted request

## Operation
- States: IDLE, DRAIN, FLUSH, DONE.
- IDLE: any request input high → latch kind bits `need_dc` (fence_i | fence_i_i), `need_ic` (fence_i_i), `need_tlb` (sfence_vma_i); clear timeout_o; go DRAIN.
- Simultaneous requests in the same cycle are merged by OR of kind bits; no priority.
- Requests arriving outside IDLE are ignored. Commit is halted, so none are legal.
- DRAIN: wait for stores_empty_i=1. Then go FLUSH if `need_dc`, else go DONE.
- FLUSH: flush_dcache_o=1; cycle counter increments from 0.
  - flush_dcache_ack_i=1 → go DONE.
  - ACK_TIMEOUT≠0 and counter = ACK_TIMEOUT−1 without ack → set timeout_o and go DONE.
  - Ack and timeout in the same cycle → ack wins; timeout_o stays 0.
- DONE (exactly one cycle): flush_pipeline_o=1, set_pc_commit_o=1, flush_icache_o=`need_ic`, flush_tlb_o=`need_tlb`; then go IDLE.
- halt_o = busy_o = (state≠IDLE).
- Counter width: $clog2(ACK_TIMEOUT+1), minimum 1. The counter never wraps; it resets to 0 on FLUSH entry.
- An ack received outside FLUSH is ignored.
- Reset values: state IDLE, counter 0, all kind bits 0. All outputs 0, including timeout_o.
- Reset mid-operation returns to IDLE immediately (async). flush_dcache_o drops with reset; no completion pulses are emitted.

## Timing
- Request accepted in cycle 0. State DRAIN and halt_o=1 from cycle 1.
- If stores_empty_i=1 in cycle 1: FLUSH in cycle 2, flush_dcache_o=1 from cycle 2.
- Ack sampled in cycle k: flush_dcache_o=0 and DONE pulses in cycle k+1; IDLE and halt_o=0 in cycle k+2.
- Minimum SFENCE.VMA latency (stores already empty): DONE in cycle 2, IDLE in cycle 3.
- All outputs are decoded from registered state/kind bits; there is no combinational input→output path.

## Configuration
- `WT_DCACHE_EN` defined (write-through DCache): FLUSH state is never entered.
  - DRAIN always goes to DONE.
  - flush_dcache_o and timeout_o are tied to 0; the counter is removed.
- `WT_DCACHE_EN` undefined: full sequence as above.

## Test plan
- fence_i pulse, stores_empty_i=1, ack at cycle 6 → flush_dcache_o high in cycles 2–6; pulses in cycle 7; halt_o high in cycles 1–7.
- fence_i_i with stores_empty_i held 0 until cycle 5, ack 2 cycles after FLUSH entry → FLUSH from cycle 6, DONE in cycle 9 with flush_icache_o=1 and flush_tlb_o=0.
- sfence_vma_i and fence_i in the same cycle → DCache flush performed, then DONE with flush_tlb_o=1 and flush_icache_o=0.
- ACK_TIMEOUT=4, no ack → flush_dcache_o high 4 cycles, then DONE with timeout_o=1; next request clears timeout_o.
- rst_ni asserted during FLUSH → all outputs 0 immediately; a later ack produces no pulses; a new fence_i restarts from DRAIN.
- With `WT_DCACHE_EN`: fence_i with stores empty → flush_dcache_o never 1; DONE in cycle 2.

Source files
------------

// File: rtl/fence_sequencer.sv
// Sequencer for FENCE / FENCE.I / SFENCE.VMA: halts commit, drains stores, flushes DCache, then
// pulses the ICache/TLB/pipeline flushes. Define WT_DCACHE_EN for a write-through DCache build.
module fence_sequencer #(
   parameter int unsigned ACK_TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic fence_i,
   input  logic fence_i_i,
   input  logic sfence_vma_i,
   input  logic stores_empty_i,
   output logic flush_dcache_o,
   input  logic flush_dcache_ack_i,
   output logic flush_icache_o,
   output logic flush_tlb_o,
   output logic flush_pipeline_o,
   output logic set_pc_commit_o,
   output logic halt_o,
   output logic busy_o,
   output logic timeout_o
);

   typedef enum logic [1:0] {StIdle, StDrain, StFlush, StDone} state_e;

   state_e state_q;
   logic   need_ic_q, need_tlb_q;
   logic   flush_icache_q, flush_tlb_q, flush_pipe_q, busy_q;
   logic   req, drain_to_done, flush_end, go_done;

   assign req = fence_i | fence_i_i | sfence_vma_i;

`ifndef WT_DCACHE_EN
   localparam int unsigned CntW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntLast = (ACK_TIMEOUT > 0) ? CntW'(ACK_TIMEOUT - 1) : '0;
   localparam logic [CntW-1:0] CntMax = '1;

   logic [CntW-1:0] cnt_q;
   logic            need_dc_q, flush_dc_q, timeout_q, ack_timeout;

   assign ack_timeout   = (ACK_TIMEOUT != 0) && (cnt_q == CntLast);
   assign drain_to_done = ~need_dc_q;
   assign flush_end     = (state_q == StFlush) & (flush_dcache_ack_i | ack_timeout);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         need_dc_q  <= 1'b0;
         flush_dc_q <= 1'b0;
         timeout_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (state_q == StIdle && req) begin
            need_dc_q <= fence_i | fence_i_i;
            timeout_q <= 1'b0;
         end
         if (state_q == StDrain && stores_empty_i && need_dc_q) begin
            flush_dc_q <= 1'b1;
            cnt_q      <= '0;
         end else if (state_q == StFlush) begin
            if (flush_end) begin
               flush_dc_q <= 1'b0;
               // An ack in the timeout cycle still counts as a clean completion.
               timeout_q  <= ~flush_dcache_ack_i;
            end else if (cnt_q != CntMax) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign flush_dcache_o = flush_dc_q;
   assign timeout_o      = timeout_q;
`else
   logic unused_ack;

   assign unused_ack     = flush_dcache_ack_i;
   assign drain_to_done  = 1'b1;
   assign flush_end      = 1'b0;
   assign flush_dcache_o = 1'b0;
   assign timeout_o      = 1'b0;
`endif

   assign go_done = ((state_q == StDrain) & stores_empty_i & drain_to_done) | flush_end;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= StIdle;
         need_ic_q      <= 1'b0;
         need_tlb_q     <= 1'b0;
         flush_icache_q <= 1'b0;
         flush_tlb_q    <= 1'b0;
         flush_pipe_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         flush_pipe_q   <= go_done;
         flush_icache_q <= go_done & need_ic_q;
         flush_tlb_q    <= go_done & need_tlb_q;
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  need_ic_q  <= fence_i_i;
                  need_tlb_q <= sfence_vma_i;
                  busy_q     <= 1'b1;
                  state_q    <= StDrain;
               end
            end
            StDrain: begin
               if (stores_empty_i) state_q <= drain_to_done ? StDone : StFlush;
            end
            StFlush: begin
               if (flush_end) state_q <= StDone;
            end
            StDone: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign flush_icache_o   = flush_icache_q;
   assign flush_tlb_o      = flush_tlb_q;
   assign flush_pipeline_o = flush_pipe_q;
   assign set_pc_commit_o  = flush_pipe_q;
   assign halt_o           = busy_q;
   assign busy_o           = busy_q;

endmodule

// File: tb/tb_fence_sequencer.sv
// Bench for fence_sequencer: two instances (default and ACK_TIMEOUT=4) share stimulus and are
// compared cycle by cycle against a transaction-level model.
module tb_fence_sequencer;

`ifdef WT_DCACHE_EN
   localparam bit Wt = 1'b1;
`else
   localparam bit Wt = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n, fence, fence_ii, sfence, stores_empty, ack;
   logic dc_b, ic_b, tlb_b, pipe_b, pc_b, halt_b, busy_b, to_b;
   logic dc_s, ic_s, tlb_s, pipe_s, pc_s, halt_s, busy_s, to_s;
   logic [7:0] got_b, got_s;

   int n_checks = 0;
   int n_fail   = 0;
   bit to_prev_b, to_prev_s;

   always #5 clk = ~clk;

   fence_sequencer u_dut_big (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .fence_i           (fence),
      .fence_i_i         (fence_ii),
      .sfence_vma_i      (sfence),
      .stores_empty_i    (stores_empty),
      .flush_dcache_o    (dc_b),
      .flush_dcache_ack_i(ack),
      .flush_icache_o    (ic_b),
      .flush_tlb_o       (tlb_b),
      .flush_pipeline_o  (pipe_b),
      .set_pc_commit_o   (pc_b),
      .halt_o            (halt_b),
      .busy_o            (busy_b),
      .timeout_o         (to_b)
   );

   fence_sequencer #(.ACK_TIMEOUT(4)) u_dut_small (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .fence_i           (fence),
      .fence_i_i         (fence_ii),
      .sfence_vma_i      (sfence),
      .stores_empty_i    (stores_empty),
      .flush_dcache_o    (dc_s),
      .flush_dcache_ack_i(ack),
      .flush_icache_o    (ic_s),
      .flush_tlb_o       (tlb_s),
      .flush_pipeline_o  (pipe_s),
      .set_pc_commit_o   (pc_s),
      .halt_o            (halt_s),
      .busy_o            (busy_s),
      .timeout_o         (to_s)
   );

   assign got_b = {dc_b, ic_b, tlb_b, pipe_b, pc_b, halt_b, busy_b, to_b};
   assign got_s = {dc_s, ic_s, tlb_s, pipe_s, pc_s, halt_s, busy_s, to_s};

   typedef struct {
      logic [2:0] kind;        // {sfence, fence.i, fence}
      int         drain;       // cycles stores_empty stays 0 after acceptance
      int         ack_dly;     // ack this many cycles after FLUSH entry
      int         done_big;
      int         done_small;
      bit         to_small;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: dc,ic,tlb,pipe,pc,halt,busy,to got %b required %b", name, got, exp);
      end
   endtask

   // Transaction model: request in cycle 0, DRAIN exit at 1+d, DONE cycle and timeout result.
   function automatic void model(input logic [2:0] k, input int d, input int a, input int t,
                                 output int done, output bit to);
      int f;
      to = 1'b0;
      if (Wt || !(k[0] | k[1])) begin
         done = d + 2;
      end else begin
         f = d + 2;
         if (t != 0 && a > t - 1) begin
            done = f + t;
            to   = 1'b1;
         end else begin
            done = f + a + 1;
         end
      end
   endfunction

   function automatic logic [7:0] expv(input logic [2:0] k, input int c, input int e,
                                       input int dn, input bit tp, input bit tn);
      bit need_dc, at_done, dc, busy, to;
      need_dc = (k[0] | k[1]) && !Wt;
      at_done = (c == dn);
      dc      = need_dc && c > e && c < dn;
      busy    = c >= 1 && c <= dn;
      to      = (c == 0) ? tp : ((c < dn) ? 1'b0 : tn);
      return {dc, at_done & k[1], at_done & k[2], at_done, at_done, busy, busy, to};
   endfunction

   // Entered and left 1ns after a rising edge.
   task automatic run_txn(input string tag, input logic [2:0] k, input int d, input int a,
                          input int done_b, input int done_s, input bit tn_b, input bit tn_s,
                          input bit noisy);
      int e, ackc, last, busy_min;
      e        = 1 + d;
      ackc     = e + 1 + a;
      busy_min = (done_b < done_s) ? done_b : done_s;
      last     = (done_b > done_s) ? done_b : done_s;
      if (ackc > last) last = ackc;
      last = last + 1;
      for (int c = 0; c <= last; c++) begin
         {sfence, fence_ii, fence} = 3'b000;
         if (c == 0) {sfence, fence_ii, fence} = k;
         else if (noisy && c <= busy_min) {sfence, fence_ii, fence} = 3'($urandom_range(0, 7));
         if (c >= 1 && c <= d) stores_empty = 1'b0;
         else if (c == e) stores_empty = 1'b1;
         else stores_empty = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (c == ackc) ack = 1'b1;
         else ack = (noisy && c <= e) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         check($sformatf("%s big cyc%0d", tag, c), got_b, expv(k, c, e, done_b, to_prev_b, tn_b));
         check($sformatf("%s small cyc%0d", tag, c), got_s,
               expv(k, c, e, done_s, to_prev_s, tn_s));
         @(posedge clk);
         #1;
      end
      to_prev_b = tn_b;
      to_prev_s = tn_s;
   endtask

   initial begin
      int  db, ds;
      bit  tb_, ts_;
      logic [2:0] k;
      int  d, a;

`ifdef WT_DCACHE_EN
      vecs[0] = '{3'b001, 0, 4, 2, 2, 1'b0};
      vecs[1] = '{3'b010, 4, 2, 6, 6, 1'b0};
      vecs[2] = '{3'b101, 0, 1, 2, 2, 1'b0};
      vecs[3] = '{3'b100, 0, 0, 2, 2, 1'b0};
      vecs[4] = '{3'b001, 0, 3, 2, 2, 1'b0};
      vecs[5] = '{3'b011, 1, 7, 3, 3, 1'b0};
`else
      vecs[0] = '{3'b001, 0, 4, 7, 6, 1'b1};
      vecs[1] = '{3'b010, 4, 2, 9, 9, 1'b0};
      vecs[2] = '{3'b101, 0, 1, 4, 4, 1'b0};
      vecs[3] = '{3'b100, 0, 0, 2, 2, 1'b0};
      vecs[4] = '{3'b001, 0, 3, 6, 6, 1'b0};
      vecs[5] = '{3'b011, 1, 7, 11, 7, 1'b1};
`endif

      rst_n = 1'b0;
      {fence, fence_ii, sfence, ack} = 4'b0000;
      stores_empty = 1'b1;
      to_prev_b = 1'b0;
      to_prev_s = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset big", got_b, 8'h00);
      check("reset small", got_s, 8'h00);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].kind, vecs[i].drain, vecs[i].ack_dly,
                 vecs[i].done_big, vecs[i].done_small, 1'b0, vecs[i].to_small, 1'b0);

      // Reset while flushing: outputs drop at once and a late ack is ignored.
      fence = 1'b1;
      stores_empty = 1'b1;
      @(posedge clk);
      #1;
      fence = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("pre-reset big", got_b, expv(3'b001, 3, 1, Wt ? 2 : 1000, 1'b0, 1'b0));
      check("pre-reset small", got_s, expv(3'b001, 3, 1, Wt ? 2 : 1000, 1'b0, 1'b0));
      rst_n = 1'b0;
      #1;
      check("async reset big", got_b, 8'h00);
      check("async reset small", got_s, 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ack = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("post-reset big cyc%0d", c), got_b, 8'h00);
         check($sformatf("post-reset small cyc%0d", c), got_s, 8'h00);
         @(posedge clk);
         #1;
         ack = 1'b0;
      end
      to_prev_b = 1'b0;
      to_prev_s = 1'b0;
      model(3'b001, 0, 2, 1024, db, tb_);
      model(3'b001, 0, 2, 4, ds, ts_);
      run_txn("restart", 3'b001, 0, 2, db, ds, tb_, ts_, 1'b0);

      for (int n = 0; n < 40; n++) begin
         k = 3'($urandom_range(1, 7));
         d = $urandom_range(0, 4);
         a = $urandom_range(0, 6);
         model(k, d, a, 1024, db, tb_);
         model(k, d, a, 4, ds, ts_);
         run_txn($sformatf("rnd%0d", n), k, d, a, db, ds, tb_, ts_, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
